// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch path
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction storage with synchronous write and combinational read
module imem_array #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = "",
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: latency-modelling instruction memory behind a valid/ready fetch port
module imem_responder
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              LATENCY     = 2
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] Iaddress,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] Instr,
  output logic            rsp_fault,
  input  logic            ld_en,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [XLEN-1:0] ld_data,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  imem_state_t     state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [AW-1:0]   idx_q, req_idx, ld_idx, rd_idx;
  logic            fault_q, req_fault, rd_fault;
  logic            acc, load_rsp, ld_we;
  logic [XLEN-1:0] rd_data;
  function automatic logic [XLEN-1:0] offset(input logic [XLEN-1:0] a);
    return a - BASE_ADDR;
  endfunction
  // addresses below BASE_ADDR wrap to huge offsets and land in the range check
  function automatic logic bad_addr(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00) || ((offset(a) >> 2) >= XLEN'(DEPTH_WORDS));
  endfunction
  assign req_idx   = AW'(offset(Iaddress) >> 2);
  assign req_fault = bad_addr(Iaddress);
  assign ld_idx    = AW'(offset(ld_addr) >> 2);
  assign ld_we     = (state == IDLE) && ld_en && !bad_addr(ld_addr);
  assign req_ready = (state == IDLE) ? !ld_en : (state == RESP) ? rsp_ready : 1'b0;
  assign acc       = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  // with single-cycle latency the response is read straight from the request
  assign rd_idx    = (state == WAIT) ? idx_q : req_idx;
  assign rd_fault  = (state == WAIT) ? fault_q : req_fault;
  imem_array #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (ld_we),
    .waddr (ld_idx),
    .wdata (ld_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );
  // next state and wait counter; RESP is entered LATENCY-1 edges after acceptance
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    unique case (state)
      IDLE: state_n = IDLE;
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = RESP;
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (acc) begin
      state_n = (LATENCY == 1) ? RESP : WAIT;
      cnt_n   = 4'(LATENCY - 1);
    end
    load_rsp = (state_n == RESP) && ((state == WAIT) || acc);
  end
  // state, captured request and held response registers
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      fault_q   <= 1'b0;
      Instr     <= '0;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (acc) begin
        idx_q   <= req_idx;
        fault_q <= req_fault;
      end
      if (load_rsp) begin
        Instr     <= rd_fault ? '0 : rd_data;
        rsp_fault <= rd_fault;
      end
    end
endmodule
